strobe_sequencer: RTL and testbench

//  Drives the 'en' inputs of a bank of positive-edge strobe gates, one per

---
 rtl/strobe_sequencer.sv | 159 +++++++++++++++
 tb/tb_strobe_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/strobe_sequencer.sv
// strobe_sequencer: one-hot phase enables for a bank of posedge strobe gates.
// The control FSM, phase, counter and done pulse live on the rising edge. The
// enables are re-registered on the falling edge so they are settled half a
// period before every rising edge, which is when the gates sample them.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no cycle in progress, en=0, phase=0
//   RUN    | sequencing continuously, one phase per clock
//   DRAIN  | run dropped; finishing the current cycle, then IDLE
//   PAUSE  | frozen by hold, en=0; origin_q says where to resume
//   STEP   | single phase fired while paused, then back to PAUSE
module strobe_sequencer #(
  parameter int PHASES = 4,
  parameter int PW     = 2,
  parameter int CW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              hold,
  input  logic              step,
  output logic [PHASES-1:0] en,
  output logic [PW-1:0]     phase,
  output logic              busy,
  output logic              cycle_done,
  output logic [CW-1:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  state_t            state_q;
  state_t            origin_q;
  logic [PW-1:0]     phase_q;
  logic [CW-1:0]     count_q;
  logic              done_q;
  logic              busy_q;
  logic              armed_q;
  logic [PHASES-1:0] en_q;

  logic              last;
  logic [PW-1:0]     phase_inc;
  logic              fire;

  assign last      = (phase_q == LAST);
  assign phase_inc = last ? '0 : phase_q + 1'b1;
  assign fire      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_STEP);

  // Control FSM: phase advance, cycle accounting, pause/step bookkeeping.
  // A step is accepted only after step has been seen low (armed_q), so a held
  // step level produces exactly one phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      origin_q <= S_IDLE;
      phase_q  <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      done_q  <= 1'b0;
      armed_q <= armed_q | ~step;
      case (state_q)
        S_IDLE: begin
          if (run && !hold) begin
            state_q <= S_RUN;
            phase_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (hold) begin
            state_q  <= S_PAUSE;
            origin_q <= S_RUN;
          end else begin
            phase_q <= phase_inc;
            if (last) begin
              count_q <= count_q + 1'b1;
              done_q  <= 1'b1;
            end
            // Dropping run on the final phase completes the cycle outright.
            if (!run) begin
              if (last) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (hold) begin
            state_q  <= S_PAUSE;
            origin_q <= S_DRAIN;
          end else begin
            phase_q <= phase_inc;
            if (last) begin
              count_q <= count_q + 1'b1;
              done_q  <= 1'b1;
            end
            if (run) begin
              state_q <= S_RUN;
            end else if (last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (!hold) begin
            state_q <= origin_q;
            busy_q  <= (origin_q != S_IDLE);
          end else if (step && armed_q && (origin_q != S_IDLE)) begin
            state_q <= S_STEP;
            armed_q <= 1'b0;
          end
        end
        S_STEP: begin
          state_q <= S_PAUSE;
          phase_q <= phase_inc;
          if (last) begin
            count_q <= count_q + 1'b1;
            done_q  <= 1'b1;
            // A drain finished by stepping has nothing left to resume into.
            if (origin_q == S_DRAIN) origin_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Falling-edge retime of the one-hot enables from the rising-edge state.
  always_ff @(negedge clk) begin
    if (!rst_n) en_q <= '0;
    else        en_q <= fire ? (PHASES'(1) << phase_q) : '0;
  end

  assign en          = en_q;
  assign phase       = phase_q;
  assign busy        = busy_q;
  assign cycle_done  = done_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Bench for strobe_sequencer: directed scenarios with literal expectations,
// then random run/hold/step/reset traffic against a behavioural model. Two
// instances share the stimulus: CW=8 and CW=2 (counter wrap).
module tb_strobe_sequencer;
  localparam int PHASES = 4;
  localparam int PW     = 2;
  localparam int T      = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0, run = 1'b1, hold = 1'b0, step = 1'b0;

  logic [PHASES-1:0] en_a, en_b;
  logic [PW-1:0]     phase_a, phase_b;
  logic              busy_a, busy_b, done_a, done_b;
  logic [7:0]        count_a;
  logic [1:0]        count_b;

  int n_vec = 0;
  int n_bad = 0;

  always #(T/2) clk = ~clk;

  strobe_sequencer #(.PHASES(PHASES), .PW(PW), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .hold(hold), .step(step),
    .en(en_a), .phase(phase_a), .busy(busy_a), .cycle_done(done_a),
    .cycle_count(count_a));

  strobe_sequencer #(.PHASES(PHASES), .PW(PW), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run), .hold(hold), .step(step),
    .en(en_b), .phase(phase_b), .busy(busy_b), .cycle_done(done_b),
    .cycle_count(count_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a cycle is either in progress or not, may be paused,
  // may be draining, and a single step fires one phase while paused.
  bit m_valid = 0;
  bit m_seq, m_drain, m_paused, m_stepping, m_armed, m_done;
  bit was_armed, completes;
  int m_ph, m_cnt;

  task automatic m_advance();
    if (m_ph == PHASES - 1) begin
      m_ph = 0;
      m_cnt++;
      m_done = 1;
    end else begin
      m_ph++;
    end
  endtask

  time t_rise = 0;

  always @(posedge clk) begin
    t_rise = $time;
    if (!rst_n) begin
      m_seq = 0; m_drain = 0; m_paused = 0; m_stepping = 0;
      m_armed = 1; m_done = 0; m_ph = 0; m_cnt = 0;
      m_valid = 1;
    end else if (m_valid) begin
      was_armed = m_armed;
      completes = (m_ph == PHASES - 1);
      m_done    = 0;
      m_armed   = m_armed | !step;
      if (m_stepping) begin
        m_advance();
        m_stepping = 0;
        if (completes && m_drain) begin m_seq = 0; m_drain = 0; end
      end else if (m_paused) begin
        if (!hold) m_paused = 0;
        else if (step && was_armed && m_seq) begin m_stepping = 1; m_armed = 0; end
      end else if (m_seq) begin
        if (hold) m_paused = 1;
        else begin
          m_advance();
          if (m_drain) begin
            if (run) m_drain = 0;
            else if (completes) begin m_seq = 0; m_drain = 0; end
          end else if (!run) begin
            if (completes) m_seq = 0;
            else m_drain = 1;
          end
        end
      end else if (run && !hold) begin
        m_seq = 1; m_drain = 0; m_ph = 0;
      end
    end
  end

  // Single compare process, just after each falling edge.
  logic [PHASES-1:0] exp_en;
  always @(negedge clk) begin
    #1;
    if (m_valid) begin
      exp_en = '0;
      if (rst_n && (m_stepping || (m_seq && !m_paused))) exp_en = PHASES'(1) << m_ph;
      chk("en_a", en_a, exp_en);
      chk("en_b", en_b, exp_en);
      chk("phase_a", phase_a, m_ph);
      chk("phase_b", phase_b, m_ph);
      chk("busy_a", busy_a, m_seq || m_paused);
      chk("busy_b", busy_b, m_seq || m_paused);
      chk("done_a", done_a, m_done);
      chk("done_b", done_b, m_done);
      chk("count_a", count_a, m_cnt % 256);
      chk("count_b", count_b, m_cnt % 4);
      chk("onehot0_en", $onehot0(en_a), 1);
    end
  end

  // en may only move in the middle half of the period between rising edges.
  time d;
  always @(en_a or en_b) begin
    if (m_valid) begin
      d = $time - t_rise;
      chk("en_timing", (d >= T/4) && (d <= T - T/4), 1);
    end
  end

  task automatic apply(input logic r, input logic ru, input logic h, input logic s);
    rst_n = r; run = ru; hold = h; step = s;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  logic [3:0] lit_en;

  initial begin
    // Reset with run asserted.
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    chk("rst_en", en_a, 4'b0000);
    chk("rst_phase", phase_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", count_a, 0);

    // Continuous run: first edge leaves IDLE, then one phase per clock.
    for (int k = 1; k <= 9; k++) begin
      apply(1, 1, 0, 0);
      lit_en = 4'b0001 << ((k - 1) % 4);
      chk("run_en", en_a, lit_en);
      chk("run_done", done_a, (k == 5 || k == 9));
    end
    chk("run_count", count_a, 2);

    // Drain: run dropped while phase 1 is firing; phases 2,3 still fire.
    apply(1, 1, 0, 0);
    chk("pre_drain_en", en_a, 4'b0010);
    apply(1, 0, 0, 0);
    chk("drain_en2", en_a, 4'b0100);
    apply(1, 0, 0, 0);
    chk("drain_en3", en_a, 4'b1000);
    apply(1, 0, 0, 0);
    chk("drain_idle_en", en_a, 4'b0000);
    chk("drain_busy", busy_a, 0);
    chk("drain_count", count_a, 3);

    // Hold and step at phase 2.
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    chk("pre_hold_en", en_a, 4'b0100);
    apply(1, 1, 1, 0);
    chk("hold_en", en_a, 4'b0000);
    chk("hold_phase", phase_a, 2);
    apply(1, 1, 1, 1);
    chk("step_en", en_a, 4'b0100);
    apply(1, 1, 1, 0);
    chk("step_after_en", en_a, 4'b0000);
    chk("step_after_phase", phase_a, 3);
    apply(1, 1, 0, 0);
    chk("resume_en", en_a, 4'b1000);
    apply(1, 1, 0, 0);
    chk("resume_count", count_a, 4);

    // Reset mid-run at phase 2: partial cycle aborted.
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    chk("pre_rst_phase", phase_a, 2);
    apply(0, 1, 0, 0);
    chk("midrst_phase", phase_a, 0);
    chk("midrst_en", en_a, 4'b0000);
    chk("midrst_count", count_a, 0);

    // Five full cycles: the 2-bit counter wraps 3 -> 0 -> 1.
    for (int k = 1; k <= 21; k++) begin
      apply(1, 1, 0, 0);
      if (k == 13) chk("wrap_count3", count_b, 3);
      if (k == 17) chk("wrap_count0", count_b, 0);
    end
    chk("wrap_count_a", count_a, 5);
    chk("wrap_count_b", count_b, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 75),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
